// File: rtl/tpu_mac_cell.sv
// Weight-stationary MAC processing element with a double-buffered weight and a sticky overflow flag.
// Optional macro TPU_MAC_SAT_EN: saturate psum_out on overflow instead of wrapping.
module tpu_mac_cell #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                     C,
  input  logic                     Rn,
  input  logic                     w_shift,
  input  logic        [DATA_W-1:0] w_in,
  output logic        [DATA_W-1:0] w_out,
  input  logic                     w_swap,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic                     a_vld_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic                     a_vld_out,
  input  logic signed [ACC_W-1:0]  psum_in,
  output logic signed [ACC_W-1:0]  psum_out,
  output logic                     p_vld_out,
  output logic                     ovf
);

  logic        [DATA_W-1:0]   w_shadow_reg;
  logic signed [DATA_W-1:0]   w_active_reg;
  logic signed [DATA_W-1:0]   a_out_reg;
  logic                       a_vld_reg;
  logic signed [ACC_W-1:0]    psum_reg;
  logic                       p_vld_reg;
  logic                       ovf_reg;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    sum;
  logic                       ovf_now;
  logic signed [ACC_W-1:0]    psum_next;

  assign prod     = a_in * w_active_reg;
  assign prod_ext = ACC_W'(prod);
  assign sum      = psum_in + prod_ext;
  // Signed overflow: operands agree in sign but the wrapped sum does not.
  assign ovf_now  = (psum_in[ACC_W-1] == prod_ext[ACC_W-1]) &&
                    (sum[ACC_W-1] != psum_in[ACC_W-1]);

`ifdef TPU_MAC_SAT_EN
  // Clamp toward the true result; the operand sign tells the direction.
  always_comb begin
    psum_next = sum;
    if (ovf_now) begin
      if (psum_in[ACC_W-1])
        psum_next = {1'b1, {(ACC_W-1){1'b0}}};
      else
        psum_next = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign psum_next = sum;
`endif

  always_ff @(posedge C or negedge Rn) begin
    if (!Rn) begin
      w_shadow_reg <= '0;
      w_active_reg <= '0;
      a_out_reg    <= '0;
      a_vld_reg    <= 1'b0;
      psum_reg     <= '0;
      p_vld_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      if (w_shift)
        w_shadow_reg <= w_in;
      // The product above already used the pre-swap weight this cycle.
      if (w_swap)
        w_active_reg <= w_shadow_reg;
      a_vld_reg <= a_vld_in;
      p_vld_reg <= a_vld_in;
      if (a_vld_in) begin
        a_out_reg <= a_in;
        psum_reg  <= psum_next;
      end
      if (a_vld_in && ovf_now)
        ovf_reg <= 1'b1;
      else if (w_swap)
        ovf_reg <= 1'b0;
    end
  end

  assign w_out     = w_shadow_reg;
  assign a_out     = a_out_reg;
  assign a_vld_out = a_vld_reg;
  assign psum_out  = psum_reg;
  assign p_vld_out = p_vld_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_tpu_mac_cell.sv
// Scoreboard bench for tpu_mac_cell: directed vectors push expected results, a monitor pops and compares.
module tb_tpu_mac_cell;

  logic        C = 1'b0;
  logic        Rn = 1'b0;
  logic        w_shift = 1'b0, w_swap = 1'b0, a_vld_in = 1'b0;
  logic [7:0]  w_in = '0, a_in = '0;
  logic [31:0] psum_in = '0;
  logic [7:0]  w_out, a_out;
  logic        a_vld_out, p_vld_out, ovf;
  logic [31:0] psum_out;

  // three-cell weight chain
  logic        ch_shift = 1'b0;
  logic [7:0]  ch_win = '0;
  logic [7:0]  top_w, mid_w, bot_w;
  logic [7:0]  ch_aout [3];
  logic        ch_av [3], ch_pv [3], ch_ovf [3];
  logic [31:0] ch_psum [3];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    logic [31:0] psum;
    logic [7:0]  aout;
    logic        av;
    logic        pv;
    logic        ov;
    logic [7:0]  wout;
  } exp_t;
  exp_t sb[$];

`ifdef TPU_MAC_SAT_EN
  localparam logic [31:0] POS_OVF = 32'h7FFF_FFFF;
  localparam logic [31:0] NEG_OVF = 32'h8000_0000;
`else
  localparam logic [31:0] POS_OVF = 32'h8000_3F00;
  localparam logic [31:0] NEG_OVF = 32'h7FFF_C080;
`endif

  tpu_mac_cell dut (
    .C(C), .Rn(Rn), .w_shift(w_shift), .w_in(w_in), .w_out(w_out), .w_swap(w_swap),
    .a_in(a_in), .a_vld_in(a_vld_in), .a_out(a_out), .a_vld_out(a_vld_out),
    .psum_in(psum_in), .psum_out(psum_out), .p_vld_out(p_vld_out), .ovf(ovf)
  );

  tpu_mac_cell u_top (
    .C(C), .Rn(Rn), .w_shift(ch_shift), .w_in(ch_win), .w_out(top_w), .w_swap(1'b0),
    .a_in(8'd0), .a_vld_in(1'b0), .a_out(ch_aout[0]), .a_vld_out(ch_av[0]),
    .psum_in(32'd0), .psum_out(ch_psum[0]), .p_vld_out(ch_pv[0]), .ovf(ch_ovf[0])
  );
  tpu_mac_cell u_mid (
    .C(C), .Rn(Rn), .w_shift(ch_shift), .w_in(top_w), .w_out(mid_w), .w_swap(1'b0),
    .a_in(8'd0), .a_vld_in(1'b0), .a_out(ch_aout[1]), .a_vld_out(ch_av[1]),
    .psum_in(32'd0), .psum_out(ch_psum[1]), .p_vld_out(ch_pv[1]), .ovf(ch_ovf[1])
  );
  tpu_mac_cell u_bot (
    .C(C), .Rn(Rn), .w_shift(ch_shift), .w_in(mid_w), .w_out(bot_w), .w_swap(1'b0),
    .a_in(8'd0), .a_vld_in(1'b0), .a_out(ch_aout[2]), .a_vld_out(ch_av[2]),
    .psum_in(32'd0), .psum_out(ch_psum[2]), .p_vld_out(ch_pv[2]), .ovf(ch_ovf[2])
  );

  always #5 C = ~C;
  always @(posedge C) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: compares every due entry on the falling edge, away from the active edge.
  always @(negedge C) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("psum_out",  psum_out,         e.psum);
      chk("a_out",     {24'd0, a_out},   {24'd0, e.aout});
      chk("a_vld_out", {31'd0, a_vld_out}, {31'd0, e.av});
      chk("p_vld_out", {31'd0, p_vld_out}, {31'd0, e.pv});
      chk("ovf",       {31'd0, ovf},     {31'd0, e.ov});
      chk("w_out",     {24'd0, w_out},   {24'd0, e.wout});
      $display("txn due=%0d psum=%h a_out=%h av=%b pv=%b ovf=%b w_out=%h",
               e.due, psum_out, a_out, a_vld_out, p_vld_out, ovf, w_out);
    end
  end

  task automatic drive(input logic sh, input logic [7:0] wi, input logic sw, input logic vl,
                       input logic [7:0] a, input logic [31:0] p,
                       input logic [31:0] e_psum, input logic [7:0] e_aout, input logic e_av,
                       input logic e_pv, input logic e_ov, input logic [7:0] e_wout);
    exp_t e;
    @(posedge C); #1;
    w_shift = sh; w_in = wi; w_swap = sw; a_vld_in = vl; a_in = a; psum_in = p;
    e.due = cyc + 1; e.psum = e_psum; e.aout = e_aout; e.av = e_av;
    e.pv = e_pv; e.ov = e_ov; e.wout = e_wout;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(posedge C);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_psum"}, psum_out, 32'd0);
    chk({tag, "_aout"}, {24'd0, a_out}, 32'd0);
    chk({tag, "_avld"}, {31'd0, a_vld_out}, 32'd0);
    chk({tag, "_pvld"}, {31'd0, p_vld_out}, 32'd0);
    chk({tag, "_ovf"},  {31'd0, ovf}, 32'd0);
    chk({tag, "_wout"}, {24'd0, w_out}, 32'd0);
  endtask

  initial begin
    // Reset held with random inputs toggling
    for (int i = 0; i < 4; i++) begin
      @(posedge C); #1;
      w_shift = 1'($urandom); w_swap = 1'($urandom); a_vld_in = 1'($urandom);
      w_in = 8'($urandom); a_in = 8'($urandom); psum_in = $urandom;
    end
    @(negedge C);
    check_all_zero("in_reset");
    @(posedge C); #1;
    w_shift = 0; w_swap = 0; a_vld_in = 0; w_in = 0; a_in = 0; psum_in = 0;
    Rn = 1'b1;

    //     sh wi     sw vl a      p             psum        aout   av pv ov wout
    drive(0, 8'd0,   0, 0, 8'd0,  32'd0,        32'd0,      8'h00, 0, 0, 0, 8'd0);
    drive(0, 8'd0,   0, 1, 8'd5,  32'd7,        32'd7,      8'h05, 1, 1, 0, 8'd0);
    drive(1, 8'd3,   0, 0, 8'd0,  32'd0,        32'd7,      8'h05, 0, 0, 0, 8'd3);
    drive(0, 8'd0,   1, 0, 8'd0,  32'd0,        32'd7,      8'h05, 0, 0, 0, 8'd3);
    drive(0, 8'd0,   0, 1, 8'hFC, 32'd100,      32'd88,     8'hFC, 1, 1, 0, 8'd3);
    drive(0, 8'd0,   0, 0, 8'd0,  32'd999,      32'd88,     8'hFC, 0, 0, 0, 8'd3);
    // swap ordering: active 2, shadow 5
    drive(1, 8'd2,   0, 0, 8'd0,  32'd0,        32'd88,     8'hFC, 0, 0, 0, 8'd2);
    drive(1, 8'd5,   1, 0, 8'd0,  32'd0,        32'd88,     8'hFC, 0, 0, 0, 8'd5);
    drive(0, 8'd0,   1, 1, 8'd10, 32'd0,        32'd20,     8'h0A, 1, 1, 0, 8'd5);
    drive(0, 8'd0,   0, 1, 8'd10, 32'd0,        32'd50,     8'h0A, 1, 1, 0, 8'd5);
    // overflow
    drive(1, 8'd127, 0, 0, 8'd0,  32'd0,        32'd50,     8'h0A, 0, 0, 0, 8'd127);
    drive(0, 8'd0,   1, 0, 8'd0,  32'd0,        32'd50,     8'h0A, 0, 0, 0, 8'd127);
    drive(0, 8'd0,   0, 1, 8'd127, 32'h7FFF_FFFF, POS_OVF,  8'h7F, 1, 1, 1, 8'd127);
    drive(0, 8'd0,   0, 1, 8'd1,  32'd0,        32'd127,    8'h01, 1, 1, 1, 8'd127);
    drive(0, 8'd0,   1, 0, 8'd0,  32'd0,        32'd127,    8'h01, 0, 0, 0, 8'd127);
    drive(0, 8'd0,   1, 1, 8'd127, 32'h7FFF_FFFF, POS_OVF,  8'h7F, 1, 1, 1, 8'd127);
    drive(0, 8'd0,   0, 1, 8'h80, 32'h8000_0000, NEG_OVF,   8'h80, 1, 1, 1, 8'd127);
    drive(0, 8'd0,   0, 0, 8'd0,  32'd0,        NEG_OVF,    8'h80, 0, 0, 1, 8'd127);
    drain();

    // Mid-operation asynchronous reset, asserted between edges
    #2 Rn = 1'b0;
    #1 check_all_zero("async_rst");
    @(posedge C); #1 Rn = 1'b1;
    drive(0, 8'd0,   0, 1, 8'd5,  32'd7,        32'd7,      8'h05, 1, 1, 0, 8'd0);
    drive(0, 8'd0,   0, 0, 8'd0,  32'd0,        32'd7,      8'h05, 0, 0, 0, 8'd0);
    drain();

    // Three-deep weight chain
    @(posedge C); #1 ch_shift = 1; ch_win = 8'd1;
    @(posedge C); #1 ch_win = 8'd2;
    @(posedge C); #1 ch_win = 8'd3;
    @(posedge C); #1 ch_shift = 0; ch_win = 8'd9;
    @(negedge C);
    chk("chain_top", {24'd0, top_w}, 32'd3);
    chk("chain_mid", {24'd0, mid_w}, 32'd2);
    chk("chain_bot", {24'd0, bot_w}, 32'd1);
    $display("chain top=%0d mid=%0d bot=%0d", top_w, mid_w, bot_w);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tpu_mac_cell.md
# tpu_mac_cell

Weight-stationary multiply-accumulate processing element for the systolic array. One instance sits between two neighbouring stages of 32-bit flip-flop pipeline registers. It takes an activation from the west and a partial sum from the north, then registers the forwarded activation east and the updated partial sum south. A double-buffered weight lets the next tile's weights shift in through a north-to-south chain while the current tile computes.

## Interface
Parameters:
- DATA_W, 8, width of activation and weight operands (signed two's complement)
- ACC_W, 32, width of partial-sum path (signed two's complement); must be ≥ 2*DATA_W

Ports:
- C  input  1  clock; all state updates on its rising edge
- Rn  input  1  asynchronous, active-low reset
- w_shift  input  1  shift w_in into the shadow weight register this cycle
- w_in  input  DATA_W  weight from the north neighbour's w_out
- w_out  output  DATA_W  current shadow weight, feeds the south neighbour's w_in
- w_swap  input  1  copy the shadow weight into the active weight
- a_in  input  DATA_W  activation from the west
- a_vld_in  input  1  a_in and psum_in are valid this cycle
- a_out  output  DATA_W  registered activation to the east
- a_vld_out  output  1  registered a_vld_in
- psum_in  input  ACC_W  partial sum from the north
- psum_out  output  ACC_W  registered partial sum to the south
- p_vld_out  output  1  psum_out is valid
- ovf  output  1  sticky flag: an accumulate overflowed ACC_W

## Operation
- State: w_shadow, w_active, a_out, a_vld_out, psum_out, p_vld_out, ovf.
- Reset (Rn low, asynchronous): all state is 0. Every output is 0 while Rn is low and on release.
- Reset asserted mid-operation aborts all state immediately. No partial result survives.
- Weight chain: when w_shift=1, w_shadow <= w_in. Otherwise w_shadow holds. w_out = w_shadow, so an N-deep column loads in N cycles.
- Weight swap: when w_swap=1, w_active <= w_shadow (pre-edge value).
- w_shift and w_swap in the same cycle: w_active receives the old shadow, and w_shadow receives w_in.
- Activation forward: a_vld_out <= a_vld_in. When a_vld_in=1, a_out <= a_in. Otherwise a_out holds.
- Accumulate: when a_vld_in=1:
  - prod = signed(a_in) * signed(w_active), a 2*DATA_W product sign-extended to ACC_W.
  - psum_out <= psum_in + prod.
  - p_vld_out <= 1.
- When a_vld_in=0: psum_out holds and p_vld_out <= 0.
- Same-cycle w_swap and a_vld_in=1: the product uses the OLD w_active. The new weight applies from the next cycle.
- Overflow: signed overflow of psum_in + prod (both operands same sign, result sign differs) sets ovf=1. Overflow is evaluated only when a_vld_in=1.
- ovf is cleared only by reset or by w_swap=1. If an overflow occurs in the same cycle as w_swap, ovf is set (set wins).
- The result wraps modulo 2^ACC_W unless saturation is compiled in (see Configuration).

## Timing
- Latency: exactly 1 cycle from a_vld_in/a_in/psum_in to a_vld_out/a_out/psum_out/p_vld_out.
- Throughput: one accumulate per cycle, with no stalls and no backpressure.
- Weight chain: 1 cycle per hop. w_swap takes effect on the first a_vld_in the cycle after it.
- Critical path: the multiply plus the ACC_W add lies between two register stages. No internal pipelining.
- Glitch-free outputs: every output is driven directly from a register.

## Configuration
- Macro: TPU_MAC_SAT_EN.
- Defined: on overflow, psum_out saturates to the ACC_W signed limit in the direction of the true result:
  - positive overflow gives 2^(ACC_W-1)-1;
  - negative overflow gives -2^(ACC_W-1).
  - ovf behaves as above.
- Undefined: psum_out wraps modulo 2^ACC_W, and ovf is still set. Saturation logic is absent from the netlist.

## Test plan
- Reset: drive random inputs with Rn=0, then release. All outputs read 0 on the first edge after release, and w_active=0, so a_in=5, psum_in=7, a_vld_in=1 gives psum_out=7.
- Load/compute: w_shift=1, w_in=3, then w_swap=1; next cycle a_in=-4, psum_in=100, a_vld_in=1. One cycle later psum_out=88, a_out=-4, p_vld_out=1, a_vld_out=1.
- Swap ordering: active weight 2, shadow weight 5, w_swap=1 together with a_in=10, psum_in=0. psum_out=20. The next valid a_in=10 gives 50.
- Hold: after a valid result of 88, drive a_vld_in=0 with psum_in=999. psum_out stays 88, p_vld_out=0, and a_out is unchanged.
- Overflow: w_active=127, a_in=127, psum_in=2^31-1. ovf=1, and ovf stays 1 through later valid cycles until w_swap. psum_out = 2^31-1 with TPU_MAC_SAT_EN defined, and -2^31+16128 without it.
- Chain: three cells cascaded via w_out→w_in, with w_shift held 3 cycles on w_in=1,2,3. Shadows read bottom=1, middle=2, top=3.
